stage_ir_multi: RTL and testbench

- Parametrised successor of the single-slot in-order retire stage.
- Retires up to RETIRE_W ROB heads per cycle and drives free-list/map-table retire and architectural writeback reporting.
- Keeps a per-ROB-index side table of completed store and branch results, replacing the single capture register, so several stores/branches can be in flight.
- Commits stores into an in-order store drain queue that empties into Dmem through a valid/ready handshake; a taken branch raises a registered interrupt/redirect.

---
 rtl/stage_ir_multi_if.sv | 87 ++++++++
 rtl/stage_ir_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_stage_ir_multi.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ir_multi_if.sv
// ============================================================================
//  Module      : stage_ir_multi_if
//  Description : Bundle for the multi-slot retire stage. It carries the
//                completion capture bus, the ROB head slots, the retire
//                report outputs, the redirect/halt status and the Dmem
//                store drain handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface stage_ir_multi_if #(
  parameter int RETIRE_W = 2,
  parameter int ROB_SZ   = 32,
  parameter int PRF_SZ   = 64,
  parameter int XLEN     = 32
);
  localparam int ROBW = $clog2(ROB_SZ);
  localparam int TW   = $clog2(PRF_SZ);

  // completion capture
  logic                       ic_valid;
  logic [ROBW-1:0]            ic_rob_idx;
  logic                       ic_wr_mem;
  logic                       ic_take_branch;
  logic [XLEN-1:0]            ic_addr;
  logic [XLEN-1:0]            ic_data;
  logic [1:0]                 ic_size;

  // ROB head slots, slot 0 oldest
  logic [RETIRE_W-1:0]        rob_valid;
  logic [RETIRE_W*ROBW-1:0]   rob_idx;
  logic [RETIRE_W-1:0]        rob_has_dest;
  logic [RETIRE_W*TW-1:0]     rob_t;
  logic [RETIRE_W*TW-1:0]     rob_t_old;
  logic [RETIRE_W*5-1:0]      rob_rd;
  logic [RETIRE_W*XLEN-1:0]   rob_npc;
  logic [RETIRE_W-1:0]        rob_wr_mem;
  logic [RETIRE_W-1:0]        rob_take_branch;
  logic [RETIRE_W-1:0]        rob_halt;
  logic [RETIRE_W*XLEN-1:0]   prf_read_out;

  // retire reporting
  logic [RETIRE_W-1:0]        retire_en;
  logic [RETIRE_W-1:0]        reg_retire_en;
  logic [RETIRE_W*TW-1:0]     prf_read_tag;
  logic [RETIRE_W*5-1:0]      wr_idx;
  logic [RETIRE_W*XLEN-1:0]   wr_data;
  logic [RETIRE_W*XLEN-1:0]   wr_npc;
  logic [3:0]                 completed_insts;

  // redirect and halt status
  logic                       interrupt;
  logic [XLEN-1:0]            branch_target;
  logic                       halted;
  logic                       halt_done;

  // store drain to Dmem
  logic                       dmem_valid;
  logic                       dmem_ready;
  logic [XLEN-1:0]            dmem_addr;
  logic [XLEN-1:0]            dmem_data;
  logic [1:0]                 dmem_size;

  // retire stage side
  modport master (
    input  ic_valid, ic_rob_idx, ic_wr_mem, ic_take_branch, ic_addr, ic_data, ic_size,
    input  rob_valid, rob_idx, rob_has_dest, rob_t, rob_t_old, rob_rd, rob_npc,
    input  rob_wr_mem, rob_take_branch, rob_halt, prf_read_out,
    output retire_en, reg_retire_en, prf_read_tag, wr_idx, wr_data, wr_npc, completed_insts,
    output interrupt, branch_target, halted, halt_done,
    output dmem_valid, dmem_addr, dmem_data, dmem_size,
    input  dmem_ready
  );

  // pipeline / memory side
  modport slave (
    output ic_valid, ic_rob_idx, ic_wr_mem, ic_take_branch, ic_addr, ic_data, ic_size,
    output rob_valid, rob_idx, rob_has_dest, rob_t, rob_t_old, rob_rd, rob_npc,
    output rob_wr_mem, rob_take_branch, rob_halt, prf_read_out,
    input  retire_en, reg_retire_en, prf_read_tag, wr_idx, wr_data, wr_npc, completed_insts,
    input  interrupt, branch_target, halted, halt_done,
    input  dmem_valid, dmem_addr, dmem_data, dmem_size,
    output dmem_ready
  );
endinterface

`default_nettype wire

// File: rtl/stage_ir_multi.sv
// ============================================================================
//  Module      : stage_ir_multi
//  Description : In-order retire stage retiring up to RETIRE_W ROB heads per
//                cycle. Completed store/branch results wait in a per-ROB-index
//                side table; retired stores drain to Dmem through an in-order
//                queue; a retired taken branch raises a one-cycle redirect.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stage_ir_multi #(
  parameter int RETIRE_W = 2,
  parameter int ROB_SZ   = 32,
  parameter int PRF_SZ   = 64,
  parameter int SQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic             clock,
  input  logic             reset,
  stage_ir_multi_if.master bus
);
  localparam int ROBW = $clog2(ROB_SZ);
  localparam int TW   = $clog2(PRF_SZ);
  localparam int SQW  = $clog2(SQ_DEPTH);
  localparam int CW   = SQW + 1;

  // side table of completed store/branch results, indexed by ROB entry
  logic [ROB_SZ-1:0]   r_st_valid;
  logic [XLEN-1:0]     r_st_addr [ROB_SZ];
  logic [XLEN-1:0]     r_st_data [ROB_SZ];
  logic [1:0]          r_st_size [ROB_SZ];
  logic [ROB_SZ-1:0]   w_st_valid_nxt;
  logic                w_capture;

  // store drain queue
  logic [XLEN-1:0]     r_sq_addr [SQ_DEPTH];
  logic [XLEN-1:0]     r_sq_data [SQ_DEPTH];
  logic [1:0]          r_sq_size [SQ_DEPTH];
  logic [SQW-1:0]      r_wr_ptr;
  logic [SQW-1:0]      r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_sq_full;
  logic                w_sq_empty;
  logic                w_pop;

  // redirect / halt state
  logic                r_interrupt;
  logic [XLEN-1:0]     r_branch_target;
  logic                r_halted;

  // slot acceptance results
  logic [RETIRE_W-1:0] w_retire_en;
  logic [RETIRE_W-1:0] w_reg_retire_en;
  logic                w_blocked;
  logic                w_ok;
  logic                w_needs_entry;
  logic [ROBW-1:0]     w_idx;
  logic                w_push;
  logic [XLEN-1:0]     w_push_addr;
  logic [XLEN-1:0]     w_push_data;
  logic [1:0]          w_push_size;
  logic                w_br_take;
  logic [XLEN-1:0]     w_br_target;
  logic                w_halt_take;
  logic [3:0]          w_completed;
  logic [RETIRE_W*5-1:0]    w_wr_idx;
  logic [RETIRE_W*XLEN-1:0] w_wr_data;
  logic [RETIRE_W*XLEN-1:0] w_wr_npc;

  // old tags are consumed by the free list directly from the ROB
  logic w_unused;
  assign w_unused = ^bus.rob_t_old;

  assign w_capture  = bus.ic_valid && (bus.ic_wr_mem || bus.ic_take_branch);
  assign w_sq_full  = (r_count == CW'(SQ_DEPTH));
  assign w_sq_empty = (r_count == '0);
  assign w_pop      = !w_sq_empty && bus.dmem_ready;

  // Accept the longest in-order prefix of slots; a store, taken branch or
  // halt ends the group, so at most one of each reaches the edge per cycle.
  always_comb begin
    w_retire_en   = '0;
    w_blocked     = r_halted;
    w_ok          = 1'b0;
    w_needs_entry = 1'b0;
    w_idx         = '0;
    w_push        = 1'b0;
    w_push_addr   = '0;
    w_push_data   = '0;
    w_push_size   = '0;
    w_br_take     = 1'b0;
    w_br_target   = '0;
    w_halt_take   = 1'b0;
    for (int i = 0; i < RETIRE_W; i++) begin
      w_idx         = bus.rob_idx[i*ROBW +: ROBW];
      w_needs_entry = bus.rob_wr_mem[i] || bus.rob_take_branch[i];
      w_ok          = !w_blocked && bus.rob_valid[i];
      if (w_needs_entry && !r_st_valid[w_idx]) w_ok = 1'b0;
      // full is checked before any same-cycle pop frees a slot
      if (bus.rob_wr_mem[i] && w_sq_full) w_ok = 1'b0;
      w_retire_en[i] = w_ok;
      if (w_ok) begin
        if (bus.rob_wr_mem[i]) begin
          w_push      = 1'b1;
          w_push_addr = r_st_addr[w_idx];
          w_push_data = r_st_data[w_idx];
          w_push_size = r_st_size[w_idx];
        end
        if (bus.rob_take_branch[i]) begin
          w_br_take   = 1'b1;
          w_br_target = r_st_addr[w_idx];
        end
        if (bus.rob_halt[i]) w_halt_take = 1'b1;
        if (w_needs_entry || bus.rob_halt[i]) w_blocked = 1'b1;
      end else begin
        w_blocked = 1'b1;
      end
    end
  end

  // Side-table valid update: captures set, retiring entries clear.
  always_comb begin
    w_st_valid_nxt = r_st_valid;
    if (w_capture) w_st_valid_nxt[bus.ic_rob_idx] = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (w_retire_en[i]) w_st_valid_nxt[bus.rob_idx[i*ROBW +: ROBW]] = 1'b0;
    end
  end

  // Side-table valid bits; a retiring taken branch flushes every entry,
  // including one being captured in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st_valid <= '0;
    end else if (w_br_take) begin
      r_st_valid <= '0;
    end else begin
      r_st_valid <= w_st_valid_nxt;
    end
  end

  // Side-table payload; only meaningful while the valid bit is set.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_st_addr[bus.ic_rob_idx] <= bus.ic_addr;
      r_st_data[bus.ic_rob_idx] <= bus.ic_data;
      r_st_size[bus.ic_rob_idx] <= bus.ic_size;
    end
  end

  // Store queue pointers and occupancy; reset discards queued stores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + SQW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + SQW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Store queue payload written at the tail.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_sq_addr[r_wr_ptr] <= w_push_addr;
      r_sq_data[r_wr_ptr] <= w_push_data;
      r_sq_size[r_wr_ptr] <= w_push_size;
    end
  end

  // Redirect pulse, its target, and the sticky halt flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_interrupt     <= 1'b0;
      r_branch_target <= '0;
      r_halted        <= 1'b0;
    end else begin
      r_interrupt <= w_br_take;
      if (w_br_take)   r_branch_target <= w_br_target;
      if (w_halt_take) r_halted        <= 1'b1;
    end
  end

  // Debug writeback fields and retire count for the accepted slots.
  always_comb begin
    w_reg_retire_en = w_retire_en & bus.rob_has_dest;
    w_wr_idx        = '0;
    w_wr_data       = '0;
    w_wr_npc        = '0;
    w_completed     = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (w_reg_retire_en[i]) begin
        w_wr_idx[i*5 +: 5]     = bus.rob_rd[i*5 +: 5];
        w_wr_data[i*XLEN +: XLEN] = bus.prf_read_out[i*XLEN +: XLEN];
      end
      if (w_retire_en[i]) w_wr_npc[i*XLEN +: XLEN] = bus.rob_npc[i*XLEN +: XLEN];
      w_completed = w_completed + 4'(w_retire_en[i]);
    end
  end

  assign bus.retire_en       = w_retire_en;
  assign bus.reg_retire_en   = w_reg_retire_en;
  assign bus.prf_read_tag    = bus.rob_t;
  assign bus.wr_idx          = w_wr_idx;
  assign bus.wr_data         = w_wr_data;
  assign bus.wr_npc          = w_wr_npc;
  assign bus.completed_insts = w_completed;
  assign bus.interrupt       = r_interrupt;
  assign bus.branch_target   = r_branch_target;
  assign bus.halted          = r_halted;
  assign bus.halt_done       = r_halted && w_sq_empty;
  assign bus.dmem_valid      = !w_sq_empty;
  assign bus.dmem_addr       = r_sq_addr[r_rd_ptr];
  assign bus.dmem_data       = r_sq_data[r_rd_ptr];
  assign bus.dmem_size       = r_sq_size[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_stage_ir_multi.sv
// ============================================================================
//  Module      : tb_stage_ir_multi
//  Description : Directed bench for stage_ir_multi. Retire decisions are
//                checked cycle by cycle; committed stores and redirects are
//                queued as expectations and compared by a negedge monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stage_ir_multi;
  localparam int RW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  stage_ir_multi_if #(.RETIRE_W(RW), .ROB_SZ(32), .PRF_SZ(64), .XLEN(32)) bus ();

  stage_ir_multi #(
    .RETIRE_W(RW), .ROB_SZ(32), .PRF_SZ(64), .SQ_DEPTH(4), .XLEN(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t         sq_exp[$];
  logic [31:0] br_exp[$];
  st_t         mon_e;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every Dmem handshake and every redirect pulse must match the
  // oldest outstanding expectation
  always @(negedge clock) begin
    if (reset) begin
      if (bus.dmem_valid && bus.dmem_ready) begin
        if (sq_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL dmem_unexpected: got addr %0h expected no store", bus.dmem_addr);
        end else begin
          mon_e = sq_exp.pop_front();
          chk("dmem_addr", bus.dmem_addr, mon_e.addr);
          chk("dmem_data", bus.dmem_data, mon_e.data);
          chk("dmem_size", bus.dmem_size, mon_e.size);
        end
      end
      if (bus.interrupt) begin
        if (br_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL redirect_unexpected: got target %0h expected no redirect", bus.branch_target);
        end else begin
          chk("branch_target", bus.branch_target, br_exp.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_rob();
    bus.rob_valid = '0; bus.rob_idx = '0; bus.rob_has_dest = '0;
    bus.rob_t = '0; bus.rob_t_old = '0; bus.rob_rd = '0; bus.rob_npc = '0;
    bus.rob_wr_mem = '0; bus.rob_take_branch = '0; bus.rob_halt = '0;
    bus.prf_read_out = '0;
  endtask

  task automatic no_cap();
    bus.ic_valid = 1'b0; bus.ic_rob_idx = '0; bus.ic_wr_mem = 1'b0;
    bus.ic_take_branch = 1'b0; bus.ic_addr = '0; bus.ic_data = '0; bus.ic_size = '0;
  endtask

  task automatic cap(input int idx, input bit st, input bit br,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.ic_valid = 1'b1; bus.ic_rob_idx = 5'(idx); bus.ic_wr_mem = st;
    bus.ic_take_branch = br; bus.ic_addr = a; bus.ic_data = d; bus.ic_size = sz;
  endtask

  task automatic slot(input int s, input int idx, input bit dest,
                      input bit st, input bit br, input bit halt);
    bus.rob_valid[s]       = 1'b1;
    bus.rob_idx[s*5 +: 5]  = 5'(idx);
    bus.rob_has_dest[s]    = dest;
    bus.rob_wr_mem[s]      = st;
    bus.rob_take_branch[s] = br;
    bus.rob_halt[s]        = halt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    idle_rob(); no_cap(); bus.dmem_ready = 1'b1;

    // reset state
    @(negedge clock);
    chk("rst_retire_en", bus.retire_en, 0);
    chk("rst_completed", bus.completed_insts, 0);
    chk("rst_interrupt", bus.interrupt, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_halt_done", bus.halt_done, 0);
    chk("rst_dmem_valid", bus.dmem_valid, 0);

    // two ALU slots retire together
    tick(); reset = 1'b1;
    slot(0, 0, 1, 0, 0, 0); slot(1, 1, 1, 0, 0, 0);
    bus.rob_t = {6'd6, 6'd5}; bus.rob_t_old = {6'd2, 6'd1};
    bus.rob_rd = {5'd4, 5'd3}; bus.rob_npc = {32'h108, 32'h104};
    bus.prf_read_out = {32'h66, 32'h55};
    @(negedge clock);
    chk("alu_retire_en", bus.retire_en, 2'b11);
    chk("alu_reg_retire_en", bus.reg_retire_en, 2'b11);
    chk("alu_completed", bus.completed_insts, 2);
    chk("alu_prf_tag", bus.prf_read_tag, {6'd6, 6'd5});
    chk("alu_wr_idx", bus.wr_idx, {5'd4, 5'd3});
    chk("alu_wr_data", bus.wr_data, {32'h66, 32'h55});

    // store waits for its capture; same-cycle capture is not yet visible
    tick(); idle_rob(); slot(0, 3, 0, 1, 0, 0);
    @(negedge clock); chk("st_no_capture", bus.retire_en, 0);
    tick(); cap(3, 1, 0, 32'h100, 32'hAB, 2'd2);
    @(negedge clock); chk("st_same_cycle_capture", bus.retire_en, 0);
    tick(); no_cap();
    @(negedge clock);
    chk("st_retire", bus.retire_en, 2'b01);
    chk("st_reg_retire_en", bus.reg_retire_en, 0);
    sq_exp.push_back('{32'h100, 32'hAB, 2'd2});
    tick(); idle_rob();
    @(negedge clock);
    chk("st_dmem_valid", bus.dmem_valid, 1);
    chk("st_dmem_addr", bus.dmem_addr, 32'h100);

    // fill the queue one store per cycle, then stall on full
    for (int k = 0; k < 5; k++) begin
      tick(); cap(4 + k, 1, 0, 32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 2'd2);
    end
    tick(); no_cap(); bus.dmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle_rob(); slot(0, 4 + k, 0, 1, 0, 0); slot(1, 5 + k, 0, 1, 0, 0);
      @(negedge clock); chk("sq_one_store_per_cycle", bus.retire_en, 2'b01);
      sq_exp.push_back('{32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 2'd2});
      tick();
    end
    idle_rob(); slot(0, 8, 0, 1, 0, 0);
    @(negedge clock); chk("sq_full_stall", bus.retire_en, 0);
    tick();
    @(negedge clock); chk("sq_full_stall_hold", bus.retire_en, 0);
    tick(); bus.dmem_ready = 1'b1;
    @(negedge clock); chk("sq_full_pop_same_cycle", bus.retire_en, 0);
    tick(); bus.dmem_ready = 1'b0;
    @(negedge clock); chk("sq_after_pop", bus.retire_en, 2'b01);
    sq_exp.push_back('{32'h210, 32'h1004, 2'd2});
    tick(); idle_rob(); bus.dmem_ready = 1'b1;
    for (int n = 0; n < 20 && bus.dmem_valid; n++) tick();
    @(negedge clock);
    chk("sq_drained", bus.dmem_valid, 0);
    chk("sq_sb_empty", sq_exp.size(), 0);

    // taken branch: redirect, younger slot held, side table flushed
    tick(); cap(9, 0, 1, 32'h2000, 32'h0, 2'd0);
    tick(); cap(10, 1, 0, 32'h400, 32'h44, 2'd2);
    tick(); cap(12, 1, 0, 32'h300, 32'h33, 2'd2);
    slot(0, 9, 0, 0, 1, 0); slot(1, 11, 1, 0, 0, 0);
    @(negedge clock); chk("br_retire_en", bus.retire_en, 2'b01);
    br_exp.push_back(32'h2000);
    tick(); no_cap(); idle_rob();
    @(negedge clock); chk("br_interrupt", bus.interrupt, 1);
    tick();
    @(negedge clock);
    chk("br_interrupt_one_cycle", bus.interrupt, 0);
    chk("br_target_hold", bus.branch_target, 32'h2000);
    tick(); slot(0, 12, 0, 1, 0, 0);
    @(negedge clock); chk("br_same_cycle_capture_dropped", bus.retire_en, 0);
    tick(); idle_rob(); slot(0, 10, 0, 1, 0, 0);
    @(negedge clock);
    chk("br_table_flushed", bus.retire_en, 0);
    chk("br_sb_empty", br_exp.size(), 0);

    // halt with two stores queued
    tick(); idle_rob(); bus.dmem_ready = 1'b0; cap(13, 1, 0, 32'h500, 32'h55, 2'd1);
    tick(); cap(14, 1, 0, 32'h504, 32'h56, 2'd0);
    tick(); no_cap(); slot(0, 13, 0, 1, 0, 0);
    @(negedge clock); chk("halt_st0_retire", bus.retire_en, 2'b01);
    sq_exp.push_back('{32'h500, 32'h55, 2'd1});
    tick(); idle_rob(); slot(0, 14, 0, 1, 0, 0);
    @(negedge clock); chk("halt_st1_retire", bus.retire_en, 2'b01);
    sq_exp.push_back('{32'h504, 32'h56, 2'd0});
    tick(); idle_rob(); slot(0, 15, 0, 0, 0, 1); slot(1, 16, 1, 0, 0, 0);
    @(negedge clock); chk("halt_retire_en", bus.retire_en, 2'b01);
    tick(); idle_rob(); slot(0, 17, 1, 0, 0, 0);
    @(negedge clock);
    chk("halt_halted", bus.halted, 1);
    chk("halt_ignores_rob", bus.retire_en, 0);
    chk("halt_done_queue_busy", bus.halt_done, 0);
    tick(); bus.dmem_ready = 1'b1;
    @(negedge clock); chk("halt_done_two_left", bus.halt_done, 0);
    tick();
    @(negedge clock); chk("halt_done_one_left", bus.halt_done, 0);
    tick();
    @(negedge clock);
    chk("halt_done_rise", bus.halt_done, 1);
    chk("halt_sb_empty", sq_exp.size(), 0);
    tick(); #2 reset = 1'b0;
    #1 chk("rst_clears_halted", bus.halted, 0);

    // reset with three stores queued and a redirect pending
    tick(); reset = 1'b1; idle_rob(); bus.dmem_ready = 1'b0;
    cap(1, 1, 0, 32'h600, 32'h61, 2'd2);
    tick(); cap(2, 1, 0, 32'h604, 32'h62, 2'd2);
    tick(); cap(3, 1, 0, 32'h608, 32'h63, 2'd2); slot(0, 1, 0, 1, 0, 0);
    @(negedge clock); chk("rq_st1", bus.retire_en, 2'b01);
    tick(); cap(4, 0, 1, 32'h700, 32'h0, 2'd0); idle_rob(); slot(0, 2, 0, 1, 0, 0);
    @(negedge clock); chk("rq_st2", bus.retire_en, 2'b01);
    tick(); no_cap(); idle_rob(); slot(0, 3, 0, 1, 0, 0);
    @(negedge clock); chk("rq_st3", bus.retire_en, 2'b01);
    tick(); idle_rob(); slot(0, 4, 0, 0, 1, 0);
    @(negedge clock); chk("rq_br", bus.retire_en, 2'b01);
    tick(); idle_rob();
    chk("rq_pre_interrupt", bus.interrupt, 1);
    chk("rq_pre_dmem_valid", bus.dmem_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rq_async_dmem_valid", bus.dmem_valid, 0);
    chk("rq_async_interrupt", bus.interrupt, 0);
    chk("rq_async_halted", bus.halted, 0);
    chk("rq_async_target", bus.branch_target, 0);
    tick(); reset = 1'b1;
    @(negedge clock);
    chk("final_dmem_valid", bus.dmem_valid, 0);
    chk("final_sb_empty", sq_exp.size() + br_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
